// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths, writeback FSM states and helpers
package regfile_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } wb_state_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
        return NUM_REGS'(1) << rd;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);
    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter with post-reset register clear
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [REG_ADDR_W*NUM_REQ-1:0] req_rd,
    input  logic [XLEN*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rf_regWrite,
    output logic [REG_ADDR_W-1:0]         rf_addr,
    output logic [XLEN-1:0]               rf_dataIn,
    output logic [NUM_REGS-1:0]           pending,
    output logic                          busy
);
    localparam int        PTR_W       = $clog2(NUM_REQ);
    localparam wb_state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

    wb_state_t             state, state_d;
    logic [REG_ADDR_W-1:0] clr_addr, clr_addr_d;
    logic [PTR_W-1:0]      rr_ptr, ptr_next;
    logic                  wr_q;
    logic [REG_ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]       data_q;
    logic [NUM_REGS-1:0]   pending_q, pending_d, set_mask, clr_mask;

    logic [NUM_REQ-1:0]    grant;
    logic [PTR_W-1:0]      grant_idx;
    logic                  grant_any;
    logic                  run_active, clear_active, accept;
    logic [REG_ADDR_W-1:0] acc_rd;
    logic [XLEN-1:0]       acc_data;

    rr_arbiter #(.N(NUM_REQ), .IW(PTR_W)) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .found (grant_any)
    );

    // Gating with reset keeps grants and clear writes off while reset is held low.
    assign run_active   = reset && (state == RUN);
    assign clear_active = reset && (state == CLEAR);
    assign req_ready    = run_active ? grant : '0;
    assign accept       = run_active && grant_any;
    assign acc_rd       = req_rd[REG_ADDR_W*grant_idx +: REG_ADDR_W];
    assign acc_data     = req_data[XLEN*grant_idx +: XLEN];
    assign ptr_next     = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Set wins over clear when the same register is re-accepted while being written.
    assign set_mask  = (accept && acc_rd != '0) ? reg_onehot(acc_rd) : '0;
    assign clr_mask  = wr_q ? reg_onehot(addr_q) : '0;
    assign pending_d = ((pending_q & ~clr_mask) | set_mask) & ~NUM_REGS'(1);

    always_comb begin
        state_d    = state;
        clr_addr_d = clr_addr;
        case (state)
            CLEAR: begin
                clr_addr_d = clr_addr + 1'b1;
                if (clr_addr == REG_ADDR_W'(NUM_REGS - 1))
                    state_d = RUN;
            end
            RUN: state_d = RUN;
            default: state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RESET_STATE;
            clr_addr  <= REG_ADDR_W'(1);
            rr_ptr    <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            pending_q <= '0;
        end else begin
            state    <= state_d;
            clr_addr <= clr_addr_d;
            if (state == CLEAR) begin
                wr_q      <= 1'b0;
                addr_q    <= clr_addr;
                data_q    <= '0;
                pending_q <= '0;
            end else begin
                pending_q <= pending_d;
                wr_q      <= accept && (acc_rd != '0);
                if (accept) begin
                    addr_q <= acc_rd;
                    data_q <= acc_data;
                    rr_ptr <= ptr_next;
                end
            end
        end
    end

    assign rf_regWrite = clear_active ? 1'b1     : wr_q;
    assign rf_addr     = clear_active ? clr_addr : addr_q;
    assign rf_dataIn   = clear_active ? '0       : data_q;
    assign pending     = pending_q;
    assign busy        = (state == CLEAR);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - table-driven and randomized check of regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        rf_regWrite;
    logic [4:0]  rf_addr;
    logic [31:0] rf_dataIn;
    logic [31:0] pending;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    regfile_wb_arbiter #(.NUM_REQ(3), .CLEAR_ON_RESET(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rf_regWrite (rf_regWrite),
        .rf_addr     (rf_addr),
        .rf_dataIn   (rf_dataIn),
        .pending     (pending),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference model: clear sweep position, round-robin pointer, and the write
    // accepted last cycle (which is exactly what is pending and driven this cycle).
    bit          m_clear;
    int          m_clr;
    int          m_ptr;
    bit          m_wr;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    typedef struct {
        logic [2:0]  valid;
        logic [14:0] rd;
        logic [95:0] data;
        logic [2:0]  exp_ready;
    } vec_t;
    vec_t tab[12];
    int   rr_order[6];

    function automatic void m_reset();
        m_clear = 1'b1;
        m_clr   = 1;
        m_ptr   = 0;
        m_wr    = 1'b0;
        m_addr  = 5'd0;
        m_data  = 32'd0;
    endfunction

    function automatic int model_grant(input logic [2:0] v);
        for (int k = 0; k < 3; k++) begin
            if (v[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},     {31'd0, busy},        32'd1);
        chk({tag, "_ready"},    {29'd0, req_ready},   32'd0);
        chk({tag, "_regwrite"}, {31'd0, rf_regWrite}, 32'd0);
        chk({tag, "_addr"},     {27'd0, rf_addr},     32'd0);
        chk({tag, "_data"},     rf_dataIn,            32'd0);
        chk({tag, "_pending"},  pending,              32'd0);
    endtask

    task automatic cycle(input logic [2:0] v, input logic [14:0] rd, input logic [95:0] d,
                         output logic [2:0] got_ready);
        int g;
        logic [2:0] exp_ready;
        logic [31:0] exp_pend;
        req_valid = v;
        req_rd    = rd;
        req_data  = d;
        @(negedge clk);
        g         = m_clear ? -1 : model_grant(v);
        exp_ready = (g < 0) ? 3'b000 : 3'(1 << g);
        exp_pend  = (!m_clear && m_wr) ? (32'd1 << m_addr) : 32'd0;
        got_ready = req_ready;
        chk("busy",        {31'd0, busy},        {31'd0, m_clear});
        chk("req_ready",   {29'd0, req_ready},   {29'd0, exp_ready});
        chk("rf_regWrite", {31'd0, rf_regWrite}, {31'd0, (m_clear | m_wr)});
        chk("rf_addr",     {27'd0, rf_addr},     m_clear ? m_clr : {27'd0, m_addr});
        chk("rf_dataIn",   rf_dataIn,            m_clear ? 32'd0 : m_data);
        chk("pending",     pending,              exp_pend);
        if (m_clear) begin
            m_addr = 5'(m_clr);
            m_data = 32'd0;
            m_wr   = 1'b0;
            if (m_clr == 31) m_clear = 1'b0;
            else m_clr++;
        end else if (g >= 0) begin
            m_addr = rd[5*g +: 5];
            m_data = d[32*g +: 32];
            m_wr   = (m_addr != 5'd0);
            m_ptr  = (g + 1) % 3;
        end else begin
            m_wr = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] rnd_data();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [2:0] got;
        tab[0]  = '{3'b001, {5'd0,  5'd0, 5'd0},  {32'h0, 32'h0, 32'hDEADBEEF},       3'b001};
        tab[1]  = '{3'b000, {5'd3,  5'd4, 5'd6},  {32'h1, 32'h2, 32'h3},              3'b000};
        tab[2]  = '{3'b010, {5'd0,  5'd5, 5'd0},  {32'h0, 32'h11, 32'h0},             3'b010};
        tab[3]  = '{3'b100, {5'd5,  5'd0, 5'd0},  {32'h22, 32'h0, 32'h0},             3'b100};
        tab[4]  = '{3'b000, {5'd9,  5'd9, 5'd9},  {32'h9, 32'h9, 32'h9},              3'b000};
        tab[5]  = '{3'b000, {5'd0,  5'd0, 5'd0},  {32'h0, 32'h0, 32'h0},              3'b000};
        tab[6]  = '{3'b100, {5'd31, 5'd0, 5'd0},  {32'hFFFFFFFF, 32'h0, 32'h0},       3'b100};
        tab[7]  = '{3'b000, {5'd0,  5'd0, 5'd0},  {32'h0, 32'h0, 32'h0},              3'b000};
        tab[8]  = '{3'b011, {5'd7,  5'd8, 5'd10}, {32'hA7, 32'hA8, 32'hA10},          3'b001};
        tab[9]  = '{3'b101, {5'd12, 5'd0, 5'd13}, {32'hB12, 32'h0, 32'hB13},          3'b100};
        tab[10] = '{3'b110, {5'd14, 5'd15, 5'd0}, {32'hC14, 32'hC15, 32'h0},          3'b010};
        tab[11] = '{3'b011, {5'd0,  5'd16, 5'd17}, {32'h0, 32'hD16, 32'hD17},         3'b001};
        rr_order = '{0, 1, 2, 0, 1, 2};

        reset     = 1'b0;
        req_valid = 3'b111;
        req_rd    = 15'h7FFF;
        req_data  = '1;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("in_reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 31; i++) cycle(3'b111, 15'($urandom), rnd_data(), got);
        for (int i = 0; i < 6; i++) begin
            cycle(3'b111, 15'($urandom), rnd_data(), got);
            chk("rr_order", {29'd0, got}, 32'd1 << rr_order[i]);
        end

        for (int i = 0; i < 12; i++) begin
            cycle(tab[i].valid, tab[i].rd, tab[i].data, got);
            chk("table_ready", {29'd0, got}, {29'd0, tab[i].exp_ready});
        end

        for (int i = 0; i < 300; i++) cycle(3'($urandom), 15'($urandom), rnd_data(), got);

        req_valid = 3'b111;
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("mid_transfer_reset");
        @(posedge clk);
        #1;
        m_reset();
        reset = 1'b1;
        for (int i = 0; i < 16; i++) cycle(3'b111, 15'($urandom), rnd_data(), got);
        chk("clear_at_17", {27'd0, rf_addr}, 32'd17);
        #1;
        reset = 1'b0;
        #1;
        chk_reset_outputs("mid_clear_reset");
        @(posedge clk);
        #1;
        m_reset();
        reset = 1'b1;
        for (int i = 0; i < 31; i++) cycle(3'($urandom), 15'($urandom), rnd_data(), got);
        for (int i = 0; i < 40; i++) cycle(3'($urandom), 15'($urandom), rnd_data(), got);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 3, number of writeback requesters (2..4).
REQ-002 Parameter: CLEAR_ON_RESET, default 1; when 1, all of x1..x31 are written to zero after reset.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 Port: req_valid  input  NUM_REQ  per-requester write request.
REQ-006 Port: req_rd  input  5*NUM_REQ  per-requester destination register; requester i uses bits [5i+4:5i].
REQ-007 Port: req_data  input  32*NUM_REQ  per-requester write data; requester i uses bits [32i+31:32i].
REQ-008 Port: req_ready  output  NUM_REQ  one-hot grant; a request is accepted on a cycle with valid&ready high.
REQ-009 Port: rf_regWrite  output  1  register-file write enable.
REQ-010 Port: rf_addr  output  5  register-file destination address (Addr3).
REQ-011 Port: rf_dataIn  output  32  register-file write data.
REQ-012 Port: pending  output  32  bit n high while an accepted write to xn has not yet been driven to the register file.
REQ-013 Port: busy  output  1  high while in CLEAR state.

Function
REQ-014 Two states SHALL exist: CLEAR and RUN.
REQ-015 CLEAR SHALL drive one write per cycle: rf_regWrite=1, rf_dataIn=0, rf_addr=1,2,...,31; it SHALL take 31 cycles and then enter RUN.
REQ-016 In CLEAR, req_ready SHALL be all zero.
REQ-017 With CLEAR_ON_RESET=0, the state after reset SHALL be RUN, and busy SHALL never assert.
REQ-018 In RUN, at most one req_ready bit SHALL be high per cycle, and only for a requester whose req_valid is high.
REQ-019 Arbitration SHALL be round-robin.
REQ-020 The search SHALL start at priority pointer rr_ptr.
REQ-021 After an accept by requester i, rr_ptr SHALL become (i+1) mod NUM_REQ; with no accept, rr_ptr SHALL hold.
REQ-022 req_ready SHALL be combinational from req_valid and rr_ptr, with no dependence on req_rd or req_data.
REQ-023 Latency SHALL be one cycle: a request accepted in cycle N appears on rf_regWrite, rf_addr and rf_dataIn in cycle N+1, registered.
REQ-024 An accepted request with rd=0 SHALL be consumed with rf_regWrite=0 in cycle N+1, and SHALL leave pending[0] at 0.
REQ-025 In any cycle with no accept in the previous cycle (RUN), rf_regWrite SHALL be 0; rf_addr and rf_dataIn SHALL hold their last values.
REQ-026 pending[rd] SHALL set at the edge ending accept cycle N and clear at the edge ending cycle N+1.
REQ-027 If a set and a clear of the same pending bit coincide, set SHALL win.
REQ-028 Back-to-back accepts to the same rd SHALL be written in grant order, last write wins.
REQ-029 pending[0] SHALL be constant 0.
REQ-030 Requester inputs SHALL be ignored when not granted; a held request SHALL remain valid until accepted.

Reset
REQ-031 While reset is low, the block SHALL hold: state=CLEAR (RUN if CLEAR_ON_RESET=0), clear address=1, rr_ptr=0, rf_regWrite=0, rf_addr=0, rf_dataIn=0, pending=0.
REQ-032 While reset is low, busy SHALL equal CLEAR_ON_RESET and req_ready SHALL be 0.
REQ-033 Reset asserted mid-CLEAR or mid-transfer SHALL discard all progress; the clear restarts from x1 after deassertion.
REQ-034 A request accepted in the cycle reset asserts SHALL be lost.

Structure
REQ-035 Shared package regfile_pkg SHALL hold XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and the state enum {CLEAR, RUN}.
REQ-036 The round-robin grant logic SHALL be a sub-module rr_arbiter (request and pointer in, one-hot grant and index out), reusable elsewhere.

Verification
REQ-037 Bench SHALL cover: reset release with CLEAR_ON_RESET=1 -> busy for 31 cycles, writes x1..x31 with 0 in order, then req_ready is available.
REQ-038 Bench SHALL cover: all three valid continuously, rr_ptr=0 -> grants 0,1,2,0,1,2; each write appears exactly 1 cycle after its accept.
REQ-039 Bench SHALL cover: req0 rd=0 data=0xDEADBEEF -> accepted, rf_regWrite=0 next cycle, pending stays 0.
REQ-040 Bench SHALL cover: req1 rd=5 data=0x11, then req2 rd=5 data=0x22 on consecutive cycles -> writes 0x11 then 0x22 to x5; pending[5] high continuously for 2 cycles.
REQ-041 Bench SHALL cover: reset pulsed low at clear address 17 -> outputs zero immediately (asynchronous), clear restarts at x1 after release.
REQ-042 Bench SHALL cover: only req2 valid, rd=31 data=0xFFFFFFFF -> granted first cycle, x31 written, rr_ptr becomes 0.
